// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: push strobe, FWFT read handshake and status flags of the UART receive FIFO
interface uart_rx_fifo_if #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
);
  logic              wr_tick;
  logic [DBIT-1:0]   wr_data;
  logic              rd_ready;
  logic              rd_valid;
  logic [DBIT-1:0]   rd_data;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              overflow;
  logic              clr_overflow;
  modport master (
    output wr_tick, wr_data, rd_ready, clr_overflow,
    input  rd_valid, rd_data, count, empty, full, almost_full, overflow
  );
  modport slave (
    input  wr_tick, wr_data, rd_ready, clr_overflow,
    output rd_valid, rd_data, count, empty, full, almost_full, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte buffer behind the UART receiver with FWFT read port and sticky overflow
module uart_rx_fifo #(
  parameter int DBIT     = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave b
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_LEVEL);
  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              ovf, pop, push_ok, drop;
  assign pop     = b.rd_valid & b.rd_ready;
  assign push_ok = b.wr_tick & (~b.full | pop);
  assign drop    = b.wr_tick & b.full & ~pop;
  assign b.count       = cnt;
  assign b.rd_valid    = cnt != '0;
  assign b.empty       = cnt == '0;
  assign b.full        = cnt == FULL_CNT;
  assign b.almost_full = cnt >= AF_CNT;
  assign b.overflow    = ovf;
  assign b.rd_data     = b.rd_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= b.wr_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      cnt    <= (push_ok && !pop) ? cnt + 1'b1 : (pop && !push_ok) ? cnt - 1'b1 : cnt;
      ovf    <= drop | (ovf & ~b.clr_overflow);
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver reports through its one-cycle done strobe and stores it in a circular buffer. Bytes are presented to the consuming logic through a first-word-fall-through valid/ready port. Overflow is detected and held in a sticky flag.

## Interface
- `DBIT`, 8: width of a stored byte; must match the receiver's data width.
- `ADDR_W`, 4: address width. Depth = 2^ADDR_W entries (16 by default). Legal range 1..8.
- `AF_LEVEL`, 12: `almost_full` asserts when `count >= AF_LEVEL`. Legal range 1..2^ADDR_W.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low (0 = reset asserted); release is synchronous to `clk` externally.
- `wr_tick`, input, 1: one-cycle push strobe, driven by the receiver's done strobe.
- `wr_data`, input, DBIT: byte to store, sampled when `wr_tick`=1.
- `rd_ready`, input, 1: consumer accepts the head byte this cycle.
- `rd_valid`, output, 1: head byte available.
- `rd_data`, output, DBIT: head byte. Forced to 0 whenever `rd_valid`=0.
- `count`, output, ADDR_W+1: number of stored bytes, 0..2^ADDR_W.
- `empty`, output, 1: `count`==0.
- `full`, output, 1: `count`==2^ADDR_W.
- `almost_full`, output, 1: `count >= AF_LEVEL`.
- `overflow`, output, 1: sticky; a push was dropped.
- `clr_overflow`, input, 1: synchronous clear of `overflow`.

## Operation
- Storage: 2^ADDR_W x DBIT register array, not reset. Write pointer `wr_ptr` and read pointer `rd_ptr` are ADDR_W bits wide, wrap modulo 2^ADDR_W, and reset to 0.
- `count`, `rd_valid`, `full`, `empty`, `almost_full` and `overflow` are registers, or are decoded purely from the registered `count`.
- Push request: `push` = `wr_tick`.
- Pop: `pop` = `rd_valid` & `rd_ready`.
- A push is accepted when `full`=0, or when `full`=1 and `pop`=1 in the same cycle.
- On an accepted push: `mem[wr_ptr]` <= `wr_data` and `wr_ptr` increments.
- On a pop: `rd_ptr` increments.
- `count` update:
  - +1 on accepted push without pop.
  - -1 on pop without accepted push.
  - Unchanged when both occur, or when neither occurs.
- Dropped push (`wr_tick`=1, `full`=1, `pop`=0): data discarded; pointers and `count` unchanged; `overflow` <= 1.
- `overflow` priority: set beats `clr_overflow` in the same cycle. Otherwise `clr_overflow`=1 clears it.
- `rd_valid` = (`count` != 0). `rd_data` = `rd_valid` ? `mem[rd_ptr]` : 0, read combinationally from the array.
- `rd_ready` while `rd_valid`=0 has no effect.
- Reset (asynchronous, `reset`=0):
  - `wr_ptr`=0, `rd_ptr`=0, `count`=0.
  - `rd_valid`=0, `rd_data`=0.
  - `empty`=1, `full`=0, `almost_full`=0, `overflow`=0.
  - Reset mid-operation discards all stored bytes immediately; no pop or push completes in the reset cycle.

## Timing
- Push-to-visible latency: 1 cycle. A `wr_tick` at edge N gives `rd_valid`=1 and `rd_data`=byte after edge N.
- Pop: `rd_data` advances to the next entry, or goes to 0 if the FIFO empties, after the same edge that samples `rd_ready`=1.
- Simultaneous push and pop when `count`=0 cannot occur, since `pop` requires `rd_valid`. The push lands and the byte is visible next cycle.
- Simultaneous push and pop when full: both complete; `count` stays 2^ADDR_W; `overflow` unchanged.
- Back-to-back `wr_tick` on consecutive cycles must be accepted, even though the receiver never produces them.
- Flags update on the same edge as `count`; no flag lags `count`.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset, then push 0x48, 0x69 with `rd_ready`=0 -> `count`=2, `rd_valid`=1, `rd_data`=0x48. Pull `rd_ready` high for 2 cycles -> 0x48 then 0x69 popped, `empty`=1, `rd_data`=0.
- Push 16 bytes 0x00..0x0F -> `almost_full` rises when `count` reaches 12, `full`=1 at 16. Push 0xAA -> `overflow`=1, `count`=16, and 0xAA is never read. Drain -> 0x00..0x0F in order.
- FIFO full, `wr_tick` with 0x55 and `rd_ready`=1 in the same cycle -> `count` stays 16, `overflow` stays 0, and 0x55 is the last byte read.
- Wrap-around: 40 pushes interleaved with pops at random `rd_ready` -> output sequence equals input sequence, and `count` always equals pushes minus pops.
- `overflow`=1, then `clr_overflow`=1 coincident with a dropped push -> `overflow` stays 1. Next cycle, `clr_overflow` alone -> `overflow`=0.
- Assert `reset`=0 asynchronously between clock edges with `count`=5 -> all outputs immediately take their reset values. After release, a push of 0x21 -> `rd_data`=0x21, `count`=1.
